// File: rtl/instruction_fetch_pkg.sv
// Shared types for the RV32I IF stage: fetch FSM states, NOP encoding, fetch payload.
package instruction_fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } if_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_pkt_t;

   // Instruction addresses are word aligned; low bits of a target are ignored.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// I-cache request/response bus between the IF stage (master) and the I-cache (slave).
interface instruction_fetch_if;
   import instruction_fetch_pkg::*;

   logic            inst_read;
   logic [XLEN-1:0] inst_addr;
   logic [XLEN-1:0] inst_rdata;
   logic            inst_resp;

   modport master (output inst_read, output inst_addr, input inst_rdata, input inst_resp);
   modport slave  (input inst_read, input inst_addr, output inst_rdata, output inst_resp);

endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with load enable and a parameterised reset value.
module instruction_fetch_pc_reg
   import instruction_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VAL = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_pc_next,
   output logic [XLEN-1:0] o_pc
);

   logic [XLEN-1:0] r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_VAL;
      end else if (i_load) begin
         r_pc <= i_pc_next;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I IF stage: owns the PC, fetches from the I-cache, skids on stall, squashes on redirect.
// Optional IF_PERF_CNT_EN adds saturating I-cache wait and flush counters.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [XLEN-1:0]       redirect_pc,
   instruction_fetch_if.master   icache,
   output logic [XLEN-1:0]       PC_out,
   output logic [XLEN-1:0]       instruction_out,
   output logic                  valid_out
`ifdef IF_PERF_CNT_EN
  ,output logic [31:0]           perf_icache_wait,
   output logic [31:0]           perf_flush
`endif
);

   if_state_t       r_state;
   if_state_t       w_state_next;
   logic [XLEN-1:0] w_pc;
   logic [XLEN-1:0] w_pc_next;
   logic            w_pc_load;
   logic [XLEN-1:0] w_pc_inc;
   logic [XLEN-1:0] w_target;
   logic            w_resp;
   logic            r_inst_read;
   logic [XLEN-1:0] r_inst_addr;
   logic            w_read_next;
   logic [XLEN-1:0] w_addr_next;
   fetch_pkt_t      r_skid;
   logic            w_skid_load;
   logic            w_out_load;
   fetch_pkt_t      w_out_pkt;

   assign w_resp   = r_inst_read & icache.inst_resp;
   assign w_target = align_pc(redirect_pc);
   assign w_pc_inc = w_pc + XLEN'(PC_STEP);

   instruction_fetch_pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
      .clk       (clk),
      .rst_n     (rst),
      .i_load    (w_pc_load),
      .i_pc_next (w_pc_next),
      .o_pc      (w_pc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state, PC update, request update, skid capture and output-load decision.
   always_comb begin
      w_state_next = r_state;
      w_pc_load    = 1'b0;
      w_pc_next    = w_pc;
      w_read_next  = r_inst_read;
      w_addr_next  = r_inst_addr;
      w_skid_load  = 1'b0;
      w_out_load   = 1'b0;
      w_out_pkt    = '{pc: w_pc, inst: icache.inst_rdata};
      case (r_state)
         FETCH: begin
            w_read_next = 1'b1;
            if (redirect) begin
               w_pc_load = 1'b1;
               w_pc_next = w_target;
               // An outstanding request must complete at its original address.
               if (r_inst_read && !icache.inst_resp) begin
                  w_state_next = DROP;
               end else begin
                  w_addr_next = w_target;
               end
            end else if (w_resp) begin
               w_pc_load   = 1'b1;
               w_pc_next   = w_pc_inc;
               w_addr_next = w_pc_inc;
               if (stall) begin
                  w_skid_load  = 1'b1;
                  w_read_next  = 1'b0;
                  w_state_next = HOLD;
               end else begin
                  w_out_load = 1'b1;
               end
            end else if (!r_inst_read) begin
               w_addr_next = w_pc;
            end
         end
         HOLD: begin
            w_read_next = 1'b0;
            w_out_pkt   = r_skid;
            if (redirect) begin
               w_pc_load    = 1'b1;
               w_pc_next    = w_target;
               w_read_next  = 1'b1;
               w_addr_next  = w_target;
               w_state_next = FETCH;
            end else if (!stall) begin
               w_out_load   = 1'b1;
               w_read_next  = 1'b1;
               w_addr_next  = w_pc;
               w_state_next = FETCH;
            end
         end
         DROP: begin
            w_read_next = 1'b1;
            if (redirect) begin
               w_pc_load = 1'b1;
               w_pc_next = w_target;
            end
            if (w_resp) begin
               w_addr_next  = redirect ? w_target : w_pc;
               w_state_next = FETCH;
            end
         end
         default: begin
            w_state_next = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_inst_read <= 1'b0;
         r_inst_addr <= RESET_PC;
         r_skid      <= '{pc: '0, inst: NOP_INST};
      end else begin
         r_inst_read <= w_read_next;
         r_inst_addr <= w_addr_next;
         if (w_skid_load) begin
            r_skid <= '{pc: w_pc, inst: icache.inst_rdata};
         end
      end
   end

   // Decode-facing register: redirect squashes, stall freezes, otherwise load or bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         PC_out          <= '0;
         instruction_out <= NOP_INST;
         valid_out       <= 1'b0;
      end else if (redirect) begin
         valid_out <= 1'b0;
      end else if (w_out_load) begin
         PC_out          <= w_out_pkt.pc;
         instruction_out <= w_out_pkt.inst;
         valid_out       <= 1'b1;
      end else if (!stall) begin
         valid_out <= 1'b0;
      end
   end

   assign icache.inst_read = r_inst_read;
   assign icache.inst_addr = r_inst_addr;

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_icache_wait <= '0;
         perf_flush       <= '0;
      end else begin
         if (r_inst_read && !icache.inst_resp && (perf_icache_wait != '1)) begin
            perf_icache_wait <= perf_icache_wait + 32'd1;
         end
         if (redirect && (perf_flush != '1)) begin
            perf_flush <= perf_flush + 32'd1;
         end
      end
   end
`endif

endmodule
